// File: rtl/wsa_pkg.sv
// Shared types and helpers for the wsa bitwise-unit front end.
// Holds the combined response record and the round-robin pick function.
package wsa_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int MAX_REQ        = 8;
    localparam int IDX_W          = 3;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] res_or;
        logic [DATA_W_DEFAULT-1:0] res_and;
        logic [DATA_W_DEFAULT-1:0] res_xor;
    } wsa_rsp_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First valid index after ptr, wrapping modulo n (n active requesters).
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] vld,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int                 n);
        rr_pick_t r;
        int       k;
        r = '0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            k = (int'(ptr) + i) % n;
            if (i <= n && !r.found && vld[k[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = k[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wsa_tag_fifo.sv
// In-order FIFO of requester tags for results still owed by the wsa unit.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wsa_tag_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/wsa_arb.sv
// Round-robin front end sharing one in-order wsa bitwise unit between requesters.
// Issues operand pairs, gathers the three result channels and routes the response by tag.
module wsa_arb
    import wsa_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int TAG_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_vld,
    output logic [NUM_REQ-1:0]        req_rdy,
    output logic [DATA_W-1:0]         wsa_in0,
    output logic                      wsa_in0_vld,
    input  logic                      wsa_in0_rdy,
    output logic [DATA_W-1:0]         wsa_in1,
    output logic                      wsa_in1_vld,
    input  logic                      wsa_in1_rdy,
    input  logic [DATA_W-1:0]         wsa_out0,
    input  logic                      wsa_out0_vld,
    output logic                      wsa_out0_rdy,
    input  logic [DATA_W-1:0]         wsa_out1,
    input  logic                      wsa_out1_vld,
    output logic                      wsa_out1_rdy,
    input  logic [DATA_W-1:0]         wsa_out2,
    input  logic                      wsa_out2_vld,
    output logic                      wsa_out2_rdy,
    output logic [DATA_W-1:0]         rsp_or,
    output logic [DATA_W-1:0]         rsp_and,
    output logic [DATA_W-1:0]         rsp_xor,
    output logic [NUM_REQ-1:0]        rsp_vld,
    input  logic [NUM_REQ-1:0]        rsp_rdy,
    output logic                      busy,
    output logic                      err
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [TAG_W-1:0]  rr_ptr;
    rr_pick_t          pick;
    logic [TAG_W-1:0]  grant;
    logic              accept;
    logic              unused_idx;

    logic              iss_vld_p0;
    logic              sent0_p0;
    logic              sent1_p0;
    logic [DATA_W-1:0] iss_a_p0;
    logic [DATA_W-1:0] iss_b_p0;
    logic              hs_in0;
    logic              hs_in1;
    logic              iss_done;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [TAG_W-1:0]  tag_head;

    wsa_rsp_t          res_p1;
    logic [2:0]        got_p1;
    logic [2:0]        out_hs;
    logic              rsp_all;
    logic              err_q;

    // Arbitration: accept only into an empty issue slot with tag space left
    always_comb begin
        pick    = rr_pick(MAX_REQ'(req_vld), IDX_W'(rr_ptr), NUM_REQ);
        grant   = pick.idx[TAG_W-1:0];
        accept  = pick.found & ~iss_vld_p0 & ~fifo_full;
        req_rdy = '0;
        if (accept) begin
            req_rdy[grant] = 1'b1;
        end
    end

    assign unused_idx = ^pick.idx;

    // Stage p0: issue slot, each operand channel retires independently
    assign hs_in0   = wsa_in0_vld & wsa_in0_rdy;
    assign hs_in1   = wsa_in1_vld & wsa_in1_rdy;
    assign iss_done = iss_vld_p0 & (sent0_p0 | hs_in0) & (sent1_p0 | hs_in1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= TAG_W'(NUM_REQ - 1);
            iss_vld_p0 <= 1'b0;
            sent0_p0   <= 1'b0;
            sent1_p0   <= 1'b0;
            iss_a_p0   <= '0;
            iss_b_p0   <= '0;
        end else if (accept) begin
            rr_ptr     <= grant;
            iss_vld_p0 <= 1'b1;
            iss_a_p0   <= req_a[grant*DATA_W +: DATA_W];
            iss_b_p0   <= req_b[grant*DATA_W +: DATA_W];
        end else if (iss_done) begin
            iss_vld_p0 <= 1'b0;
            sent0_p0   <= 1'b0;
            sent1_p0   <= 1'b0;
        end else begin
            if (hs_in0) begin
                sent0_p0 <= 1'b1;
            end
            if (hs_in1) begin
                sent1_p0 <= 1'b1;
            end
        end
    end

    assign wsa_in0     = iss_a_p0;
    assign wsa_in1     = iss_b_p0;
    assign wsa_in0_vld = iss_vld_p0 & ~sent0_p0;
    assign wsa_in1_vld = iss_vld_p0 & ~sent1_p0;

    wsa_tag_fifo #(
        .W     (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tags (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (grant),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (tag_head)
    );

    // Stage p1: result collection, one register and got flag per channel
    assign wsa_out0_rdy = ~got_p1[0];
    assign wsa_out1_rdy = ~got_p1[1];
    assign wsa_out2_rdy = ~got_p1[2];
    assign out_hs       = {wsa_out2_vld & wsa_out2_rdy,
                           wsa_out1_vld & wsa_out1_rdy,
                           wsa_out0_vld & wsa_out0_rdy};
    assign rsp_all      = (&got_p1) & ~fifo_empty;
    assign fifo_pop     = rsp_all & rsp_rdy[tag_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            got_p1 <= '0;
            res_p1 <= '0;
            err_q  <= 1'b0;
        end else begin
            if (fifo_pop) begin
                got_p1 <= '0;
            end else begin
                got_p1 <= got_p1 | out_hs;
            end
            if (out_hs[0]) begin
                res_p1.res_or <= DATA_W_DEFAULT'(wsa_out0);
            end
            if (out_hs[1]) begin
                res_p1.res_and <= DATA_W_DEFAULT'(wsa_out1);
            end
            if (out_hs[2]) begin
                res_p1.res_xor <= DATA_W_DEFAULT'(wsa_out2);
            end
            if ((|out_hs) && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rsp_vld = '0;
        if (rsp_all) begin
            rsp_vld[tag_head] = 1'b1;
        end
    end

    assign rsp_or  = res_p1.res_or[DATA_W-1:0];
    assign rsp_and = res_p1.res_and[DATA_W-1:0];
    assign rsp_xor = res_p1.res_xor[DATA_W-1:0];
    assign busy    = ~fifo_empty | iss_vld_p0;
    assign err     = err_q;

endmodule

// File: tb/tb_wsa_arb.sv
// Bench for wsa_arb: behavioural wsa unit model plus a grant/response scoreboard.
module tb_wsa_arb;

    localparam int NUM_REQ   = 2;
    localparam int DATA_W    = 32;
    localparam int TAG_DEPTH = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ-1:0]        req_rdy;
    logic [DATA_W-1:0]         wsa_in0;
    logic                      wsa_in0_vld;
    logic                      wsa_in0_rdy;
    logic [DATA_W-1:0]         wsa_in1;
    logic                      wsa_in1_vld;
    logic                      wsa_in1_rdy;
    logic [DATA_W-1:0]         wsa_out0 = '0;
    logic                      wsa_out0_vld;
    logic                      wsa_out0_rdy;
    logic [DATA_W-1:0]         wsa_out1 = '0;
    logic                      wsa_out1_vld;
    logic                      wsa_out1_rdy;
    logic [DATA_W-1:0]         wsa_out2 = '0;
    logic                      wsa_out2_vld;
    logic                      wsa_out2_rdy;
    logic [DATA_W-1:0]         rsp_or;
    logic [DATA_W-1:0]         rsp_and;
    logic [DATA_W-1:0]         rsp_xor;
    logic [NUM_REQ-1:0]        rsp_vld;
    logic [NUM_REQ-1:0]        rsp_rdy;
    logic                      busy;
    logic                      err;

    int errors = 0;
    int checks = 0;

    wsa_arb #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .wsa_in0      (wsa_in0),
        .wsa_in0_vld  (wsa_in0_vld),
        .wsa_in0_rdy  (wsa_in0_rdy),
        .wsa_in1      (wsa_in1),
        .wsa_in1_vld  (wsa_in1_vld),
        .wsa_in1_rdy  (wsa_in1_rdy),
        .wsa_out0     (wsa_out0),
        .wsa_out0_vld (wsa_out0_vld),
        .wsa_out0_rdy (wsa_out0_rdy),
        .wsa_out1     (wsa_out1),
        .wsa_out1_vld (wsa_out1_vld),
        .wsa_out1_rdy (wsa_out1_rdy),
        .wsa_out2     (wsa_out2),
        .wsa_out2_vld (wsa_out2_vld),
        .wsa_out2_rdy (wsa_out2_rdy),
        .rsp_or       (rsp_or),
        .rsp_and      (rsp_and),
        .rsp_xor      (rsp_xor),
        .rsp_vld      (rsp_vld),
        .rsp_rdy      (rsp_rdy),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Unit model: pairs operands in arrival order, results appear two cycles later
    typedef struct {
        logic [DATA_W-1:0] r_or;
        logic [DATA_W-1:0] r_and;
        logic [DATA_W-1:0] r_xor;
        int                rdy_at;
    } ures_t;

    ures_t             uq[$];
    logic [DATA_W-1:0] qa[$];
    logic [DATA_W-1:0] qb[$];
    logic [2:0]        udone = '0;
    logic [2:0]        u_vld = '0;
    logic              force_out0 = 1'b0;
    int                cyc = 0;
    int                d1 = 0;

    assign wsa_out0_vld = u_vld[0] | force_out0;
    assign wsa_out1_vld = u_vld[1];
    assign wsa_out2_vld = u_vld[2];

    always @(posedge clk) begin
        ures_t nr;
        logic [DATA_W-1:0] ua, ub;
        cyc = cyc + 1;
        if (rst) begin
            uq.delete();
            qa.delete();
            qb.delete();
            udone = '0;
        end else begin
            if (wsa_in0_vld && wsa_in0_rdy) qa.push_back(wsa_in0);
            if (wsa_in1_vld && wsa_in1_rdy) qb.push_back(wsa_in1);
            if (uq.size() > 0) begin
                if (wsa_out0_vld && wsa_out0_rdy) udone[0] = 1'b1;
                if (wsa_out1_vld && wsa_out1_rdy) udone[1] = 1'b1;
                if (wsa_out2_vld && wsa_out2_rdy) udone[2] = 1'b1;
                if (udone == 3'b111) begin
                    void'(uq.pop_front());
                    udone = '0;
                end
            end
            while (qa.size() > 0 && qb.size() > 0) begin
                ua        = qa.pop_front();
                ub        = qb.pop_front();
                nr.r_or   = ua | ub;
                nr.r_and  = ua & ub;
                nr.r_xor  = ua ^ ub;
                nr.rdy_at = cyc + 1;
                uq.push_back(nr);
            end
        end
        if (!rst && uq.size() > 0) begin
            u_vld[0] <= !udone[0] && (cyc >= uq[0].rdy_at);
            u_vld[1] <= !udone[1] && (cyc >= uq[0].rdy_at + d1);
            u_vld[2] <= !udone[2] && (cyc >= uq[0].rdy_at);
            wsa_out0 <= uq[0].r_or;
            wsa_out1 <= uq[0].r_and;
            wsa_out2 <= uq[0].r_xor;
        end else begin
            u_vld <= '0;
        end
    end

    // Scoreboard: round-robin rule on accepts, in-order routed responses
    typedef struct {
        int                id;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   mptr = NUM_REQ - 1;
    int   n_rsp = 0;
    int   eg;
    int   ag;
    exp_t ee;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            mptr = NUM_REQ - 1;
        end else begin
            eg = -1;
            for (int i = 1; i <= NUM_REQ; i++) begin
                if (eg < 0 && req_vld[(mptr + i) % NUM_REQ]) eg = (mptr + i) % NUM_REQ;
            end
            if (req_rdy != '0) begin
                checks++;
                if (eg < 0 || req_rdy !== NUM_REQ'(1 << eg)) begin
                    errors++;
                    $display("FAIL rr_grant: req_rdy=%b with req_vld=%b, required one-hot grant of %0d",
                             req_rdy, req_vld, eg);
                end
            end
            if ((req_rdy & req_vld) != '0) begin
                ag = -1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (ag < 0 && req_rdy[i] && req_vld[i]) ag = i;
                end
                ee.id = ag;
                ee.a  = req_a[ag*DATA_W +: DATA_W];
                ee.b  = req_b[ag*DATA_W +: DATA_W];
                exp_q.push_back(ee);
                grant_log.push_back(ag);
                mptr = (eg >= 0) ? eg : ag;
            end
            if ((rsp_vld & rsp_rdy) != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: rsp_vld=%b, required no response outstanding", rsp_vld);
                end else begin
                    ee = exp_q.pop_front();
                    n_rsp++;
                    if (rsp_vld !== NUM_REQ'(1 << ee.id) || rsp_or !== (ee.a | ee.b) ||
                        rsp_and !== (ee.a & ee.b) || rsp_xor !== (ee.a ^ ee.b)) begin
                        errors++;
                        $display("FAIL rsp_data: vld=%b or=%h and=%h xor=%h, required vld=%b or=%h and=%h xor=%h",
                                 rsp_vld, rsp_or, rsp_and, rsp_xor, NUM_REQ'(1 << ee.id),
                                 ee.a | ee.b, ee.a & ee.b, ee.a ^ ee.b);
                    end
                end
            end
        end
    end

    task automatic randomize_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*DATA_W +: DATA_W] = $urandom;
            req_b[i*DATA_W +: DATA_W] = $urandom;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_rdy, wsa_in0_vld, wsa_in1_vld, rsp_vld} !== '0) begin
            errors++;
            $display("FAIL reset_vld: req_rdy=%b in_vld=%b%b rsp_vld=%b, required all 0",
                     req_rdy, wsa_in0_vld, wsa_in1_vld, rsp_vld);
        end
        checks++;
        if ({wsa_out2_rdy, wsa_out1_rdy, wsa_out0_rdy} !== 3'b111) begin
            errors++;
            $display("FAIL reset_out_rdy: %b%b%b, required 111", wsa_out2_rdy, wsa_out1_rdy, wsa_out0_rdy);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b err=%b, required 0 0", busy, err);
        end
        checks++;
        if ({wsa_in0, wsa_in1, rsp_or, rsp_and, rsp_xor} !== '0) begin
            errors++;
            $display("FAIL reset_data: in0=%h in1=%h or=%h and=%h xor=%h, required all 0",
                     wsa_in0, wsa_in1, rsp_or, rsp_and, rsp_xor);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        @(negedge clk);
        req_a[0 +: DATA_W] = 32'hF0F0_00FF;
        req_b[0 +: DATA_W] = 32'h0FF0_0F0F;
        req_vld = 2'b01;
        #1;
        checks++;
        if (req_rdy !== 2'b01) begin
            errors++;
            $display("FAIL single_req_rdy: %b, required 01", req_rdy);
        end
        @(negedge clk);
        req_vld = 2'b00;
        checks++;
        if ({wsa_in0_vld, wsa_in1_vld} !== 2'b11 || wsa_in0 !== 32'hF0F0_00FF || wsa_in1 !== 32'h0FF0_0F0F) begin
            errors++;
            $display("FAIL single_issue: vld=%b%b in0=%h in1=%h, required 11 f0f000ff 0ff00f0f",
                     wsa_in0_vld, wsa_in1_vld, wsa_in0, wsa_in1);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_vld !== 2'b00) begin
            errors++;
            $display("FAIL single_early: rsp_vld=%b at N+3, required 00", rsp_vld);
        end
        @(negedge clk);
        checks++;
        if (rsp_vld !== 2'b01 || rsp_or !== 32'hFFF0_0FFF || rsp_and !== 32'h00F0_000F || rsp_xor !== 32'hFF00_0FF0) begin
            errors++;
            $display("FAIL single_rsp: vld=%b or=%h and=%h xor=%h, required 01 fff00fff 00f0000f ff000ff0",
                     rsp_vld, rsp_or, rsp_and, rsp_xor);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_vld !== 2'b00) begin
            errors++;
            $display("FAIL single_idle: busy=%b rsp_vld=%b, required 0 00", busy, rsp_vld);
        end
    endtask

    task automatic test_alternate();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        grant_log.delete();
        req_vld = 2'b11;
        repeat (24) begin
            randomize_ops();
            @(negedge clk);
        end
        req_vld = 2'b00;
        for (int t = 0; t < 200 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0 || grant_log.size() < 8) begin
            errors++;
            $display("FAIL alt_drain: pending=%0d busy=%b grants=%0d, required 0 0 >=8",
                     exp_q.size(), busy, grant_log.size());
        end
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
            checks++;
            if (grant_log[k] != k % 2) begin
                errors++;
                $display("FAIL alt_order: grant %0d went to %0d, required %0d", k, grant_log[k], k % 2);
            end
        end
    endtask

    task automatic test_stagger();
        wsa_in1_rdy = 1'b0;
        @(negedge clk);
        randomize_ops();
        req_vld = 2'b10;
        @(negedge clk);
        req_vld = 2'b11;
        #1;
        checks++;
        if ({wsa_in0_vld, wsa_in1_vld} !== 2'b11 || req_rdy !== 2'b00) begin
            errors++;
            $display("FAIL stagger_issue: vld=%b%b req_rdy=%b, required 11 00", wsa_in0_vld, wsa_in1_vld, req_rdy);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({wsa_in0_vld, wsa_in1_vld} !== 2'b01 || req_rdy !== 2'b00) begin
                errors++;
                $display("FAIL stagger_hold: cycle %0d vld=%b%b req_rdy=%b, required 01 00",
                         k, wsa_in0_vld, wsa_in1_vld, req_rdy);
            end
        end
        wsa_in1_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if ({wsa_in0_vld, wsa_in1_vld} !== 2'b00 || req_rdy === 2'b00) begin
            errors++;
            $display("FAIL stagger_release: vld=%b%b req_rdy=%b, required 00 and nonzero",
                     wsa_in0_vld, wsa_in1_vld, req_rdy);
        end
        req_vld = 2'b00;
        for (int t = 0; t < 100 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stagger_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_backpressure();
        int n0, n1;
        rsp_rdy = 2'b00;
        n0 = grant_log.size();
        n1 = n_rsp;
        req_vld = 2'b11;
        repeat (10) begin
            randomize_ops();
            @(negedge clk);
        end
        #1;
        checks++;
        if (grant_log.size() - n0 != TAG_DEPTH || req_rdy !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_full: accepted=%0d req_rdy=%b busy=%b, required %0d 00 1",
                     grant_log.size() - n0, req_rdy, busy, TAG_DEPTH);
        end
        req_vld = 2'b00;
        rsp_rdy = 2'b11;
        for (int t = 0; t < 200 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
        checks++;
        if (n_rsp - n1 != TAG_DEPTH || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: responses=%0d pending=%0d, required %0d 0", n_rsp - n1, exp_q.size(), TAG_DEPTH);
        end
    endtask

    task automatic test_out_of_order();
        d1 = 2;
        @(negedge clk);
        randomize_ops();
        req_vld = 2'b10;
        @(negedge clk);
        req_vld = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (wsa_out0_rdy !== 1'b0 || wsa_out1_rdy !== 1'b1 || rsp_vld !== 2'b00) begin
            errors++;
            $display("FAIL ooo_partial: out0_rdy=%b out1_rdy=%b rsp_vld=%b, required 0 1 00",
                     wsa_out0_rdy, wsa_out1_rdy, rsp_vld);
        end
        @(negedge clk);
        checks++;
        if (rsp_vld !== 2'b00) begin
            errors++;
            $display("FAIL ooo_early: rsp_vld=%b at N+5, required 00", rsp_vld);
        end
        @(negedge clk);
        checks++;
        if (rsp_vld !== 2'b10) begin
            errors++;
            $display("FAIL ooo_rsp: rsp_vld=%b at N+6, required 10", rsp_vld);
        end
        d1 = 0;
        for (int t = 0; t < 100 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
    endtask

    task automatic test_random();
        d1 = int'($urandom_range(0, 2));
        repeat (300) begin
            @(negedge clk);
            randomize_ops();
            req_vld     = NUM_REQ'($urandom);
            rsp_rdy     = NUM_REQ'($urandom);
            wsa_in0_rdy = ($urandom_range(0, 3) != 0);
            wsa_in1_rdy = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        req_vld     = 2'b00;
        rsp_rdy     = 2'b11;
        wsa_in0_rdy = 1'b1;
        wsa_in1_rdy = 1'b1;
        for (int t = 0; t < 300 && (exp_q.size() != 0 || busy); t++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
        end
        d1 = 0;
    endtask

    task automatic test_reset_midflight();
        rsp_rdy = 2'b00;
        req_vld = 2'b11;
        repeat (3) begin
            randomize_ops();
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b1 || exp_q.size() != 2) begin
            errors++;
            $display("FAIL mid_inflight: busy=%b outstanding=%0d, required 1 2", busy, exp_q.size());
        end
        rst = 1'b1;
        req_vld = 2'b00;
        @(negedge clk);
        checks++;
        if ({req_rdy, wsa_in0_vld, wsa_in1_vld, rsp_vld, busy, err} !== '0 ||
            {wsa_out2_rdy, wsa_out1_rdy, wsa_out0_rdy} !== 3'b111) begin
            errors++;
            $display("FAIL mid_reset: req_rdy=%b in_vld=%b%b rsp_vld=%b busy=%b err=%b out_rdy=%b%b%b, required all 0 and 111",
                     req_rdy, wsa_in0_vld, wsa_in1_vld, rsp_vld, busy, err,
                     wsa_out2_rdy, wsa_out1_rdy, wsa_out0_rdy);
        end
        rst = 1'b0;
        rsp_rdy = 2'b11;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_vld !== 2'b00) begin
            errors++;
            $display("FAIL mid_stale: busy=%b rsp_vld=%b, required 0 00", busy, rsp_vld);
        end
    endtask

    task automatic test_error();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_idle: err=%b, required 0", err);
        end
        force_out0 = 1'b1;
        @(negedge clk);
        force_out0 = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b, required 1", err);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b, required 1", err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        req_a       = '0;
        req_b       = '0;
        req_vld     = '0;
        rsp_rdy     = '1;
        wsa_in0_rdy = 1'b1;
        wsa_in1_rdy = 1'b1;
        test_reset();
        test_single();
        test_alternate();
        test_stagger();
        test_backpressure();
        test_out_of_order();
        test_random();
        test_reset_midflight();
        test_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wsa_arb.md
Name: wsa_arb

Overview:
- Front-end scheduler that shares one wsa bitwise unit (OR/AND/XOR of two 32-bit operands) between NUM_REQ requesters.
- Round-robin arbitrates operand requests and issues each winner's operand pair on the unit's two independent input channels.
- Gathers the three independently handshaken result channels and returns the combined response, in order, to the requester that issued it.
- The unit is strictly in-order, so requester IDs travel in a tag FIFO.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 32, operand/result width; must match the unit.
- TAG_DEPTH, 4, tag FIFO entries (power of 2); must be at least 3 (issue slot + unit input reg + unit output reg).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_a  in  NUM_REQ*DATA_W  operand A per requester, slice i
- req_b  in  NUM_REQ*DATA_W  operand B per requester
- req_vld  in  NUM_REQ  request valid per requester
- req_rdy  out  NUM_REQ  request accept, one-hot or zero
- wsa_in0 / wsa_in0_vld  out  DATA_W / 1  unit operand A channel
- wsa_in0_rdy  in  1  unit accept, operand A
- wsa_in1 / wsa_in1_vld  out  DATA_W / 1  unit operand B channel
- wsa_in1_rdy  in  1  unit accept, operand B
- wsa_out0 / wsa_out0_vld  in  DATA_W / 1  OR result from unit
- wsa_out0_rdy  out  1  OR result accept
- wsa_out1 / wsa_out1_vld / wsa_out1_rdy  in/in/out  AND result channel
- wsa_out2 / wsa_out2_vld / wsa_out2_rdy  in/in/out  XOR result channel
- rsp_or, rsp_and, rsp_xor  out  DATA_W each  shared response data bus
- rsp_vld  out  NUM_REQ  response valid, one-hot or zero
- rsp_rdy  in  NUM_REQ  requester response accept
- busy  out  1  tag FIFO non-empty or issue slot full
- err  out  1  sticky: result arrived with tag FIFO empty

Behaviour:
- Reset clears everything. Outputs at reset: all vld = 0, req_rdy = 0, rsp_vld = 0, wsa_outX_rdy = 1, busy = 0, err = 0, data buses = 0. RR pointer = NUM_REQ-1, so req0 has first priority.
- Arbitration:
  - Grant g is the first i with req_vld[i] set, scanning from pointer+1 with modulo wrap.
  - req_rdy[g] = 1 only when the issue slot is empty and the tag FIFO is not full. req_rdy is combinational on req_vld.
  - On accept: the issue slot captures a, b and g; g is pushed to the tag FIFO; pointer <= g. The pointer is unchanged when there is no grant.
- Issue slot:
  - Drives wsa_in0_vld and wsa_in1_vld from registers while full.
  - Keeps per-channel sent flags; each channel's vld drops after its own rdy.
  - The slot empties when both channels are accepted (same or different cycles). A new request may be accepted in the cycle after emptying, not the same cycle.
- Collect:
  - Three result registers, each with a got flag. wsa_outX_rdy = ~gotX, so channels may arrive in any order and any cycle.
  - When all three got flags are set: rsp_vld[tag_head] = 1 and the rsp buses show the registers.
  - On rsp_rdy[tag_head]: pop the tag FIFO and clear all got flags. There is no same-cycle refill.
- Result with tag FIFO empty (any wsa_outX handshake while empty): the value is still captured and err is set until rst.
- Latency with all rdy high: req accept cycle N, wsa_in vld at N+1, unit outputs valid at N+3, rsp_vld at N+4.
- Throughput: at most one response every 2 cycles.
- Reset mid-operation drops all in-flight work. The unit shares rst, so no stale results remain.
- Tag FIFO full: every req_rdy is 0; issue and collect continue.

Decomposition:
- Shared package wsa_pkg holds:
  - DATA_W_DEFAULT
  - typedef wsa_rsp_t {or, and, xor}
  - function rr_pick(vld, ptr) returning an index and a found flag
- Sub-module: wsa_tag_fifo. Synchronous FIFO of clog2(NUM_REQ)-bit tags with push, pop, full, empty and head; ptr-wrap counters one bit wider than the address.

Test Plan:
- Single request, all rdy high:
  - Stimulus: req0 a=0xF0F0_00FF, b=0x0FF0_0F0F.
  - Required: rsp_vld=2'b01 at N+4 with or=0xFFF0_0FFF, and=0x00F0_000F, xor=0xFF00_0FF0.
- Both requesters continuously valid from reset: grants alternate 0,1,0,1; responses return in grant order with matching one-hot rsp_vld.
- Unit input rdy staggered:
  - Stimulus: wsa_in1_rdy held low 3 cycles after wsa_in0 accepted.
  - Required: in0 is not re-sent and req_rdy stays 0 until in1 is accepted; result correct.
- Response backpressure:
  - Stimulus: rsp_rdy low for 10 cycles with requests continuously valid.
  - Required: the tag FIFO fills to 4, req_rdy goes 0, no result is lost, and 4 responses drain in order after release.
- Result channels out of order: the bench delays wsa_out1 (as a unit model) by 2 cycles relative to out0/out2; rsp_vld asserts only after all three are captured.
- Reset mid-flight plus error:
  - rst asserted with 2 in flight: all vld, busy and err return to 0 the next cycle.
  - A forced wsa_out0_vld while idle sets err = 1.
